// File: rtl/shift_add_mult.sv
// Sequential shift-and-add unsigned multiplier with a valid/ready handshake on both sides.
// Optional feature macro: ZERO_BYPASS_EN (a zero operand skips straight to DONE).
module shift_add_mult #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int CNT_W  = $clog2(WIDTH + 1);
  localparam int WORK_W = 2 * WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_mcand;
  logic [WORK_W-1:0]  r_work;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;
  logic               w_last;
  logic               w_zero;

  // One combined step on {carry, acc, mplr}: conditional add into acc, then shift right with 0 into carry.
  function automatic logic [WORK_W-1:0] f_step(input logic [WORK_W-1:0] work,
                                               input logic [WIDTH-1:0]  mcand);
    logic [WIDTH:0] sum;
    if (work[0]) begin
      sum = {1'b0, work[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
    end else begin
      sum = {work[2*WIDTH], work[2*WIDTH-1:WIDTH]};
    end
    return {1'b0, sum, work[WIDTH-1:1]};
  endfunction

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef ZERO_BYPASS_EN
  assign w_zero = (multiplicand == {WIDTH{1'b0}}) || (multiplier == {WIDTH{1'b0}});
`else
  assign w_zero = 1'b0;
`endif

  // State register; reset wins over accept and out_ready.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          if (w_zero) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_CALC;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CALC: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_CALC;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: operand latch at accept, one step per CALC cycle; held otherwise.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_mcand <= {WIDTH{1'b0}};
      r_work  <= {WORK_W{1'b0}};
      r_cnt   <= {CNT_W{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_mcand <= multiplicand;
            r_cnt   <= {CNT_W{1'b0}};
            if (w_zero) begin
              r_work <= {WORK_W{1'b0}};
            end else begin
              r_work <= {{(WIDTH + 1){1'b0}}, multiplier};
            end
          end
        end
        S_CALC: begin
          r_work <= f_step(r_work, r_mcand);
          r_cnt  <= r_cnt + {{(CNT_W - 1){1'b0}}, 1'b1};
        end
        default: begin
          r_work <= r_work;
        end
      endcase
    end
  end

  // Status flags registered from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_DONE);
      r_busy      <= (w_state_nxt == S_CALC);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign product   = r_work[2*WIDTH-1:0];

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed self-checking bench: WIDTH=4 vector table plus hand-written corner sequences, and a WIDTH=8 instance.
module tb_shift_add_mult;

`ifdef ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        n_reset;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [3:0]  mcand, mplr;
  logic [7:0]  product;
  logic        in_valid8, in_ready8, out_valid8, busy8;
  logic [7:0]  mcand8, mplr8;
  logic [15:0] product8;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
  } vec_t;
  vec_t vecs[10];

  always #5 clk = ~clk;

  shift_add_mult #(.WIDTH(4)) u_dut4 (
    .clk(clk), .n_reset(n_reset), .in_valid(in_valid), .in_ready(in_ready),
    .multiplicand(mcand), .multiplier(mplr), .out_valid(out_valid),
    .out_ready(out_ready), .product(product), .busy(busy)
  );

  shift_add_mult #(.WIDTH(8)) u_dut8 (
    .clk(clk), .n_reset(n_reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .multiplicand(mcand8), .multiplier(mplr8), .out_valid(out_valid8),
    .out_ready(1'b1), .product(product8), .busy(busy8)
  );

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Issues one operation, scrambles the operands while busy, and checks latency, busy span and product.
  task automatic do_op(input string name, input logic [3:0] a, input logic [3:0] b,
                       input logic [7:0] p);
    int lat;
    int bsy;
    bit zero;
    zero = (a == 4'd0) || (b == 4'd0);
    @(negedge clk);
    check({name, " in_ready"}, int'(in_ready), 1);
    in_valid = 1'b1; mcand = a; mplr = b;
    @(negedge clk);
    mcand = ~a; mplr = ~b;
    lat = 1;
    bsy = int'(busy);
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
      bsy += int'(busy);
    end
    in_valid = 1'b0;
    check({name, " latency"}, lat, (zero && BYPASS) ? 1 : 5);
    check({name, " busy"}, bsy, (zero && BYPASS) ? 0 : 4);
    check({name, " product"}, int'(product), int'(p));
  endtask

  initial begin
    int k;
    int seen;
    vecs[0] = '{4'd8,  4'd9,  8'd72};
    vecs[1] = '{4'd15, 4'd15, 8'd225};
    vecs[2] = '{4'd1,  4'd1,  8'd1};
    vecs[3] = '{4'd3,  4'd5,  8'd15};
    vecs[4] = '{4'd15, 4'd1,  8'd15};
    vecs[5] = '{4'd2,  4'd8,  8'd16};
    vecs[6] = '{4'd12, 4'd10, 8'd120};
    vecs[7] = '{4'd7,  4'd6,  8'd42};
    vecs[8] = '{4'd0,  4'd13, 8'd0};
    vecs[9] = '{4'd9,  4'd0,  8'd0};

    n_reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; mcand = 4'd0; mplr = 4'd0;
    in_valid8 = 1'b0; mcand8 = 8'd0; mplr8 = 8'd0;
    repeat (3) @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
    check("reset product", int'(product), 0);
    check("reset in_ready", int'(in_ready), 1);
    check("reset out_valid", int'(out_valid), 0);
    check("reset busy", int'(busy), 0);
    check("reset product8", int'(product8), 0);

    for (int i = 0; i < 10; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p);
      @(negedge clk);
      check($sformatf("vec%0d back to idle", i), int'(in_ready), 1);
      check($sformatf("vec%0d product retained", i), int'(product), int'(vecs[i].p));
    end

    // Backpressure: product held for six cycles, released one edge after out_ready rises.
    out_ready = 1'b0;
    do_op("hold", 4'd15, 4'd15, 8'd225);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("hold out_valid", int'(out_valid), 1);
      check("hold product", int'(product), 225);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("release out_valid", int'(out_valid), 0);
    check("release in_ready", int'(in_ready), 1);
    check("release product", int'(product), 225);

    // Reset during the second CALC cycle aborts 7*6.
    @(negedge clk);
    in_valid = 1'b1; mcand = 4'd7; mplr = 4'd6;
    @(negedge clk);
    in_valid = 1'b0;
    check("abort busy", int'(busy), 1);
    @(negedge clk);
    n_reset = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    check("abort product", int'(product), 0);
    check("abort in_ready", int'(in_ready), 1);
    check("abort busy after", int'(busy), 0);
    check("abort out_valid", int'(out_valid), 0);
    @(negedge clk);
    check("no accept under reset", int'(in_ready), 1);
    n_reset = 1'b1; in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen += int'(out_valid);
    end
    check("no out_valid after abort", seen, 0);
    do_op("post-abort", 4'd3, 4'd5, 8'd15);

    // WIDTH=8: 255*255 back-to-back with in_valid and out_ready held high.
    @(negedge clk);
    in_valid8 = 1'b1; mcand8 = 8'd255; mplr8 = 8'd255;
    @(negedge clk);
    k = 1;
    while (!out_valid8 && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("w8 latency", k, 9);
    check("w8 product", int'(product8), 65025);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid8 && k < 30);
    in_valid8 = 1'b0;
    check("w8 issue interval", k, 10);
    check("w8 product second", int'(product8), 65025);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
